// File: rtl/pc_update_unit.sv
// Program-counter register for the multi-cycle MIPS core: next-PC mux, stall-deferred
// exceptions, misaligned-target trapping and the EPC save strobe to CP0.
module pc_update_unit #(
  parameter int          WIDTH        = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h00400000,
  parameter logic [31:0] EXC_VECTOR   = 32'h00400004
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       pc_sel,
  input  logic             pc_we,
  input  logic             stall,
  input  logic             exc_req,
  input  logic [WIDTH-1:0] z_data,
  input  logic [WIDTH-1:0] epc_data,
  input  logic [WIDTH-1:0] j_data,
  input  logic [WIDTH-1:0] jal_data,
  input  logic [WIDTH-1:0] rs_data,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_prev,
  output logic             epc_wr,
  output logic [WIDTH-1:0] epc_wdata,
  output logic             addr_err,
  output logic [WIDTH-1:0] bad_vaddr,
  output logic             exc_pending
);

  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] EXC_V = WIDTH'(EXC_VECTOR);

  typedef enum logic {RUN, PEND} state_t;

  state_t           r_state, w_state_n;
  logic [WIDTH-1:0] r_pc, r_prev, r_epc_wdata, r_bad_vaddr;
  logic             r_epc_wr, r_addr_err;

  logic [WIDTH-1:0] w_target;
  logic             w_sel_valid;
  logic [WIDTH-1:0] w_pc_n, w_prev_n, w_epc_wdata_n, w_bad_vaddr_n;
  logic             w_epc_wr_n, w_addr_err_n, w_trap;

  always_comb begin
    w_target    = r_pc;
    w_sel_valid = 1'b1;
    case (pc_sel)
      3'd0:    w_target = z_data;
      3'd1:    w_target = epc_data;
      3'd2:    w_target = jal_data;
      3'd3:    w_target = j_data;
      3'd4:    w_target = rs_data;
      3'd5:    w_target = EXC_V;
      default: w_sel_valid = 1'b0;
    endcase
  end

  always_comb begin
    w_state_n     = r_state;
    w_pc_n        = r_pc;
    w_prev_n      = r_prev;
    w_epc_wr_n    = 1'b0;
    w_epc_wdata_n = r_epc_wdata;
    w_addr_err_n  = 1'b0;
    w_bad_vaddr_n = r_bad_vaddr;
    w_trap        = 1'b0;
    case (r_state)
      RUN: begin
        if (exc_req && !stall) begin
          w_trap = 1'b1;
        end else if (exc_req && stall) begin
          w_state_n = PEND;
        end else if (stall) begin
          w_state_n = RUN;
        end else if (pc_we && w_sel_valid) begin
          if (w_target[1:0] != 2'b00) begin
            w_trap        = 1'b1;
            w_addr_err_n  = 1'b1;
            w_bad_vaddr_n = w_target;
          end else begin
            w_pc_n   = w_target;
            w_prev_n = r_pc;
          end
        end
      end
      PEND: begin
        // Deferred exception fires on the first unstalled cycle; new requests merge.
        if (!stall) begin
          w_trap    = 1'b1;
          w_state_n = RUN;
        end
      end
      default: w_state_n = RUN;
    endcase
    if (w_trap) begin
      w_pc_n        = EXC_V;
      w_prev_n      = r_pc;
      w_epc_wr_n    = 1'b1;
      w_epc_wdata_n = r_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= RST_V;
      r_prev      <= RST_V;
      r_epc_wr    <= 1'b0;
      r_epc_wdata <= '0;
      r_addr_err  <= 1'b0;
      r_bad_vaddr <= '0;
    end else begin
      r_pc        <= w_pc_n;
      r_prev      <= w_prev_n;
      r_epc_wr    <= w_epc_wr_n;
      r_epc_wdata <= w_epc_wdata_n;
      r_addr_err  <= w_addr_err_n;
      r_bad_vaddr <= w_bad_vaddr_n;
    end
  end

  assign pc_out      = r_pc;
  assign pc_prev     = r_prev;
  assign epc_wr      = r_epc_wr;
  assign epc_wdata   = r_epc_wdata;
  assign addr_err    = r_addr_err;
  assign bad_vaddr   = r_bad_vaddr;
  assign exc_pending = (r_state == PEND);

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed bench for pc_update_unit: loads, traps, deferred exceptions and async reset.
module tb_pc_update_unit;

  localparam logic [31:0] RV = 32'h00400000;
  localparam logic [31:0] EV = 32'h00400004;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  pc_sel;
  logic        pc_we, stall, exc_req;
  logic [31:0] z_data, epc_data, j_data, jal_data, rs_data;
  logic [31:0] pc_out, pc_prev, epc_wdata, bad_vaddr;
  logic        epc_wr, addr_err, exc_pending;

  int checks = 0;
  int errors = 0;

  pc_update_unit dut (
    .clk(clk), .rst(rst), .pc_sel(pc_sel), .pc_we(pc_we), .stall(stall),
    .exc_req(exc_req), .z_data(z_data), .epc_data(epc_data), .j_data(j_data),
    .jal_data(jal_data), .rs_data(rs_data), .pc_out(pc_out), .pc_prev(pc_prev),
    .epc_wr(epc_wr), .epc_wdata(epc_wdata), .addr_err(addr_err),
    .bad_vaddr(bad_vaddr), .exc_pending(exc_pending)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle outputs before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc_sel = 3'd7; pc_we = 0; stall = 0; exc_req = 0;
    z_data = 0; epc_data = 0; j_data = 0; jal_data = 0; rs_data = 0;
    #12;
    checks++; if (pc_out !== RV) begin errors++; $display("FAIL reset_pc: got %h exp %h", pc_out, RV); end
    checks++; if (pc_prev !== RV) begin errors++; $display("FAIL reset_prev: got %h exp %h", pc_prev, RV); end
    checks++; if (epc_wr !== 1'b0 || addr_err !== 1'b0 || exc_pending !== 1'b0)
      begin errors++; $display("FAIL reset_flags: got %b%b%b exp 000", epc_wr, addr_err, exc_pending); end
    checks++; if (epc_wdata !== 32'h0 || bad_vaddr !== 32'h0)
      begin errors++; $display("FAIL reset_regs: got %h %h exp 0 0", epc_wdata, bad_vaddr); end
    @(negedge clk); rst = 1'b0;
    step();
  endtask

  task automatic test_jump();
    pc_we = 1; pc_sel = 3'd3; j_data = 32'h00400100;
    step();
    pc_we = 0;
    checks++; if (pc_out !== 32'h00400100) begin errors++; $display("FAIL jump_pc: got %h exp 00400100", pc_out); end
    checks++; if (pc_prev !== RV) begin errors++; $display("FAIL jump_prev: got %h exp %h", pc_prev, RV); end
    checks++; if (epc_wr !== 1'b0 || addr_err !== 1'b0)
      begin errors++; $display("FAIL jump_flags: got %b%b exp 00", epc_wr, addr_err); end
  endtask

  task automatic test_misaligned();
    pc_we = 1; pc_sel = 3'd4; rs_data = 32'h00400102;
    step();
    pc_we = 0;
    checks++; if (pc_out !== EV) begin errors++; $display("FAIL mis_pc: got %h exp %h", pc_out, EV); end
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL mis_aerr: got %b exp 1", addr_err); end
    checks++; if (bad_vaddr !== 32'h00400102) begin errors++; $display("FAIL mis_bad: got %h exp 00400102", bad_vaddr); end
    checks++; if (epc_wr !== 1'b1 || epc_wdata !== 32'h00400100)
      begin errors++; $display("FAIL mis_epc: got %b %h exp 1 00400100", epc_wr, epc_wdata); end
    checks++; if (pc_prev !== 32'h00400100) begin errors++; $display("FAIL mis_prev: got %h exp 00400100", pc_prev); end
    step();
    checks++; if (addr_err !== 1'b0 || epc_wr !== 1'b0)
      begin errors++; $display("FAIL mis_pulse: got %b%b exp 00", addr_err, epc_wr); end
    checks++; if (bad_vaddr !== 32'h00400102 || epc_wdata !== 32'h00400100 || pc_out !== EV)
      begin errors++; $display("FAIL mis_hold: got %h %h %h", bad_vaddr, epc_wdata, pc_out); end
  endtask

  task automatic test_hold_sel();
    pc_we = 1; pc_sel = 3'd3; j_data = 32'h00400100;
    step();
    pc_sel = 3'd7; z_data = 32'h00400300; j_data = 32'h00400300;
    step();
    checks++; if (pc_out !== 32'h00400100) begin errors++; $display("FAIL sel7_hold: got %h exp 00400100", pc_out); end
    pc_sel = 3'd6;
    step();
    checks++; if (pc_out !== 32'h00400100) begin errors++; $display("FAIL sel6_hold: got %h exp 00400100", pc_out); end
    pc_sel = 3'd5;
    step();
    pc_we = 0;
    checks++; if (pc_out !== EV || pc_prev !== 32'h00400100)
      begin errors++; $display("FAIL sel5_load: got %h %h exp %h 00400100", pc_out, pc_prev, EV); end
    checks++; if (epc_wr !== 1'b0 || addr_err !== 1'b0)
      begin errors++; $display("FAIL sel5_noepc: got %b%b exp 00", epc_wr, addr_err); end
  endtask

  task automatic test_back_to_back();
    pc_we = 1; pc_sel = 3'd0; z_data = 32'h00400200;
    step();
    checks++; if (pc_out !== 32'h00400200) begin errors++; $display("FAIL b2b_z: got %h exp 00400200", pc_out); end
    pc_sel = 3'd2; jal_data = 32'h00400300;
    step();
    checks++; if (pc_out !== 32'h00400300 || pc_prev !== 32'h00400200)
      begin errors++; $display("FAIL b2b_jal: got %h %h exp 00400300 00400200", pc_out, pc_prev); end
    pc_sel = 3'd1; epc_data = 32'h00400200;
    step();
    pc_we = 0;
    checks++; if (pc_out !== 32'h00400200 || pc_prev !== 32'h00400300)
      begin errors++; $display("FAIL b2b_epc: got %h %h exp 00400200 00400300", pc_out, pc_prev); end
  endtask

  task automatic test_deferred();
    int pend_cycles = 0;
    int wr_count = 0;
    stall = 1; exc_req = 1; pc_we = 1; pc_sel = 3'd3; j_data = 32'h00400100;
    for (int i = 0; i < 3; i++) begin
      step();
      exc_req = (i == 0);  // a second request while pending must merge
      if (exc_pending === 1'b1) pend_cycles++;
      if (epc_wr === 1'b1) wr_count++;
      checks++; if (pc_out !== 32'h00400200) begin errors++; $display("FAIL pend_pc%0d: got %h exp 00400200", i, pc_out); end
    end
    exc_req = 0;
    checks++; if (pend_cycles != 3) begin errors++; $display("FAIL pend_cycles: got %0d exp 3", pend_cycles); end
    stall = 0;
    step();
    pc_we = 0;
    checks++; if (pc_out !== EV || epc_wr !== 1'b1 || epc_wdata !== 32'h00400200)
      begin errors++; $display("FAIL pend_fire: got %h %b %h exp %h 1 00400200", pc_out, epc_wr, epc_wdata, EV); end
    if (epc_wr === 1'b1) wr_count++;
    checks++; if (exc_pending !== 1'b0) begin errors++; $display("FAIL pend_clear: got %b exp 0", exc_pending); end
    for (int i = 0; i < 3; i++) begin
      step();
      if (epc_wr === 1'b1) wr_count++;
    end
    checks++; if (wr_count != 1) begin errors++; $display("FAIL pend_once: got %0d strobes exp 1", wr_count); end
    checks++; if (pc_out !== EV) begin errors++; $display("FAIL pend_after: got %h exp %h", pc_out, EV); end
  endtask

  task automatic test_exc_priority();
    pc_we = 1; pc_sel = 3'd3; j_data = 32'h00400100;
    step();
    exc_req = 1; pc_sel = 3'd0; z_data = 32'h00400200;
    step();
    exc_req = 0; pc_we = 0;
    checks++; if (pc_out !== EV || epc_wr !== 1'b1 || epc_wdata !== 32'h00400100)
      begin errors++; $display("FAIL exc_prio: got %h %b %h exp %h 1 00400100", pc_out, epc_wr, epc_wdata, EV); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL exc_prio_aerr: got %b exp 0", addr_err); end
  endtask

  task automatic test_reset_pend();
    stall = 1; exc_req = 1;
    step();
    exc_req = 0;
    checks++; if (exc_pending !== 1'b1) begin errors++; $display("FAIL rp_enter: got %b exp 1", exc_pending); end
    #2 rst = 1'b1;
    #1;
    checks++; if (pc_out !== RV || exc_pending !== 1'b0)
      begin errors++; $display("FAIL rp_async: got %h %b exp %h 0", pc_out, exc_pending, RV); end
    stall = 0;
    #3 rst = 1'b0;
    step(); step();
    checks++; if (pc_out !== RV || epc_wr !== 1'b0 || exc_pending !== 1'b0)
      begin errors++; $display("FAIL rp_nofire: got %h %b %b exp %h 0 0", pc_out, epc_wr, exc_pending, RV); end
  endtask

  initial begin
    test_reset();
    test_jump();
    test_misaligned();
    test_hold_sel();
    test_back_to_back();
    test_deferred();
    test_exc_priority();
    test_reset_pend();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_update_unit.md
Name: pc_update_unit

Overview:
- Registered program-counter update block for the multi-cycle MIPS core.
- Selects the next PC from the controller's 3-bit PC-source code and loads it under write-enable and stall control.
- Takes priority exceptions. An exception that arrives during a stall is deferred. Misaligned jump or branch targets are trapped with an address-error exception.
- Drives the EPC save strobe to the CP0 block. Sits between the controller/ALU datapath and the instruction-fetch address.

Parameters:
- WIDTH, 32: PC and data width; must be >= 3.
- RESET_VECTOR, 32'h00400000: PC value after reset.
- EXC_VECTOR, 32'h00400004: exception entry address, truncated to WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pc_sel  in  3  next-PC source: 0 Z (ALU result), 1 EPC, 2 JAL target, 3 J target, 4 RS (jr/jalr), 5 EXC_VECTOR, 6 and 7 none/hold.
- pc_we  in  1  PC write request.
- stall  in  1  freeze; while high, PC does not change.
- exc_req  in  1  external exception request (syscall, break, interrupt).
- z_data  in  WIDTH  ALU result.
- epc_data  in  WIDTH  EPC contents.
- j_data  in  WIDTH  J target.
- jal_data  in  WIDTH  JAL target.
- rs_data  in  WIDTH  register RS value.
- pc_out  out  WIDTH  current PC (registered).
- pc_prev  out  WIDTH  PC value before the last successful load.
- epc_wr  out  1  one-cycle strobe: CP0 must capture epc_wdata.
- epc_wdata  out  WIDTH  PC to save as EPC.
- addr_err  out  1  one-cycle pulse on a misaligned target trap.
- bad_vaddr  out  WIDTH  offending target of the last address error.
- exc_pending  out  1  high while in state PEND.

Behaviour:
- Reset values:
  - pc_out = RESET_VECTOR; pc_prev = RESET_VECTOR.
  - epc_wr = 0, epc_wdata = 0, addr_err = 0, bad_vaddr = 0.
  - State = RUN; exc_pending = 0.
  - Reset mid-PEND discards the deferred exception.
- Target mux is combinational and registered in the same cycle. All loads take effect at the next rising edge (1-cycle latency); pc_out never changes combinationally.
- State RUN, priority highest first:
  1. exc_req=1, stall=0: pc_out<=EXC_VECTOR; pc_prev<=pc_out; epc_wr=1 with epc_wdata=pc_out.
  2. exc_req=1, stall=1: go to PEND; PC unchanged; epc_wr=0.
  3. stall=1: hold everything.
  4. pc_we=1 and pc_sel in 0..5 with target[1:0]!=0: pc_out<=EXC_VECTOR; pc_prev<=pc_out; epc_wr=1 with epc_wdata=pc_out; addr_err=1; bad_vaddr<=target.
  5. pc_we=1 and pc_sel in 0..5 with target aligned: pc_out<=target; pc_prev<=pc_out.
  6. Otherwise (pc_we=0, or pc_sel 6/7): hold.
- pc_sel=5 loads EXC_VECTOR without epc_wr (controller-driven entry; the controller saves EPC itself).
- State PEND:
  - exc_pending=1. pc_we, pc_sel and further exc_req are ignored; repeated requests merge into one.
  - While stall=1, stay in PEND.
  - When stall=0: perform the RUN rule-1 action using the current pc_out, then return to RUN.
- epc_wr and addr_err are registered pulses, high for exactly one cycle after the triggering edge. They never assert together with a normal load.
- epc_wdata and bad_vaddr hold their last values between pulses.
- Alignment check uses the low 2 bits only. Targets are truncated to WIDTH with no wrap handling: PC arithmetic is done upstream.

Test Plan:
- Reset, then pc_we=1, pc_sel=3, j_data=32'h00400100 → next cycle pc_out=32'h00400100, pc_prev=32'h00400000, epc_wr=0.
- pc_out=32'h00400100, pc_we=1, pc_sel=4, rs_data=32'h00400102 → pc_out=32'h00400004, addr_err=1 for one cycle, bad_vaddr=32'h00400102, epc_wr=1, epc_wdata=32'h00400100.
- stall=1 with exc_req=1 for 1 cycle, stall held for 3 cycles with pc_we=1 → exc_pending=1 for 3 cycles, PC unchanged; the cycle after stall drops, pc_out=EXC_VECTOR and epc_wr=1 exactly once.
- exc_req=1 and pc_we=1 (pc_sel=0, z_data=32'h00400200) in the same cycle → exception wins: pc_out=EXC_VECTOR, epc_wdata=old pc_out.
- pc_sel=7 and pc_sel=6 with pc_we=1 → pc_out held; pc_sel=5 → pc_out=EXC_VECTOR, epc_wr=0.
- Assert rst asynchronously in PEND mid-cycle → pc_out=32'h00400000 and exc_pending=0 immediately. After release, no deferred exception fires.
